// File: rtl/dmem_responder.sv
// +----------------------------------------------------------------------+
// | dmem_responder : word data memory with a fixed-latency response, Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          addr_err;
  logic [AW-1:0] index;

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;

  assign accept       = req_valid && req_ready;
  assign misaligned   = |req_addr[1:0];
  assign out_of_range = |req_addr[31:AW+2];
  assign addr_err     = misaligned || out_of_range;
  assign index        = req_addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Leave WAIT on the edge that takes the counter to zero.
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q   <= addr_err;
        rdata_q <= (req_we || addr_err) ? 32'd0 : mem[index];
      end
    end
  end

  // Storage keeps its contents through reset; rejected writes never land.
  always_ff @(posedge clk) begin
    if (reset && accept && req_we && !addr_err) begin
      mem[index] <= req_wdata;
    end
  end

endmodule

`default_nettype wire
